// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Optional macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int               CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE     = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_acc, dvd, dvs;
  logic             sign_q, sign_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, accept, early, last_iter, q_bit;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign mag_a     = magnitude(opa, signed_div);
  assign mag_b     = magnitude(opb, signed_div);
  assign div_zero  = (opb == '0);
  assign accept    = (state == IDLE) && start && !annul;
  assign last_iter = (count == CNT_LAST);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  // One restoring step: the dividend MSB shifts into the partial remainder, quotient bit enters at the LSB
  assign shifted  = {rem_acc, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = (shifted >= {1'b0, dvs});
  assign rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {dvd[WIDTH-2:0], q_bit};

  assign stall = accept || (state == BUSY);
  assign ready = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div_zero || early) ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      rem_acc <= '0;
      dvd     <= '0;
      dvs     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      quo     <= '0;
      rem     <= '0;
    end else if (accept) begin
      count   <= '0;
      rem_acc <= '0;
      dvd     <= mag_a;
      dvs     <= mag_b;
      sign_q  <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      sign_r  <= signed_div && opa[WIDTH-1];
      if (div_zero) begin
        quo <= '1;
        rem <= opa;
      end else if (early) begin
        quo <= '0;
        rem <= opa;
      end
    end else if (state == BUSY && !annul) begin
      count   <= count + CNT_ONE;
      rem_acc <= rem_step;
      dvd     <= quo_step;
      if (last_iter) begin
        quo <= cond_neg(quo_step, sign_q);
        rem <= cond_neg(rem_step, sign_r);
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: a behavioural divide model checked every cycle,
// plus literal expectations for latency and results of each directed request.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        stall, ready;
  logic [31:0] quo, rem;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .opa(opa), .opb(opb), .stall(stall), .ready(ready), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ready_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r, output bit fast);
    longint sa, sb;
    fast = 1'b0;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      fast = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && sa < sb) fast = 1'b1;
`endif
  endfunction

  // Model: countdown of remaining edges, pending result, and last delivered result
  int          m_cnt = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, p_q, p_r;
  bit          fast;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_done = 1'b0; m_q = '0; m_r = '0;
    end else if (annul) begin
      m_cnt = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r;
      end
    end else if (start) begin
      ref_div(opa, opb, signed_div, p_q, p_r, fast);
      if (fast) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r;
      end else begin
        m_cnt = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("ready", {31'd0, ready}, {31'd0, m_done});
      check("stall", {31'd0, stall},
            {31'd0, (m_cnt > 0) || (!m_done && m_cnt == 0 && start && !annul)});
      check("quo", quo, m_q);
      check("rem", rem, m_r);
      if (ready) ready_cnt++;
    end
  end

  // Issue at posedge+2 in an idle cycle; returns at posedge+2 of the cycle after ready
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                        input int elat, input bit keep);
    int lat;
    bit got;
    opa = a; opb = b; signed_div = sgn; start = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({name, " ready_seen"}, {31'd0, got}, 32'd1);
    check({name, " latency"}, lat, elat);
    check({name, " quo"}, quo, eq);
    check({name, " rem"}, rem, er);
    @(posedge clk);
    #2;
    if (!keep) start = 1'b0;
  endtask

  localparam int EO_LAT =
`ifdef DIV_EARLY_OUT_EN
    0;
`else
    32;
`endif

  initial begin
    int rc;
    repeat (2) @(negedge clk);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd0);
    check("rst quo", quo, 32'd0);
    check("rst rem", rem, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;

    run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32, 1'b0);
    run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32, 1'b0);
    run_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 32, 1'b0);
    run_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 32, 1'b0);
    run_op("div x/0", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 0, 1'b0);
    run_op("divu x/0", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 0, 1'b0);

    // Abort mid-iteration: no completion, results untouched
    rc = ready_cnt;
    opa = 32'd1000; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 annul = 1'b1;
    @(posedge clk);
    #2 annul = 1'b0;
    @(negedge clk);
    check("annul stall", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    check("annul no ready", ready_cnt - rc, 32'd0);
    check("annul quo kept", quo, 32'hFFFF_FFFF);
    check("annul rem kept", rem, 32'h1234);
    @(posedge clk);
    #2;
    run_op("divu 9/4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 32, 1'b0);

    // Back-to-back with start held through DONE
    rc = ready_cnt;
    run_op("divu 50/5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 32, 1'b1);
    run_op("divu 51/5", 32'd51, 32'd5, 1'b0, 32'd10, 32'd1, 32, 1'b0);
    repeat (40) @(negedge clk);
    check("b2b pulses", ready_cnt - rc, 32'd2);
    check("b2b idle stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #2;

    run_op("divu 3/10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, EO_LAT, 1'b0);
    run_op("div -3/10", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, EO_LAT, 1'b0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the DIV/DIVU requests flagged by the decode stage (isDiv).
- Sits in the execute stage beside the ALU.
- Accepts a start request, holds the pipeline via stall while iterating, then presents quotient (to LO) and remainder (to HI) with a one-cycle ready pulse that qualifies the hilo write.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  divide request (E-stage instruction is DIV/DIVU and valid)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- annul  input  1  flush/exception in E stage; abort current operation
- opa  input  WIDTH  dividend (rs)
- opb  input  WIDTH  divisor (rt)
- stall  output  1  hold IF/ID/E while division outstanding
- ready  output  1  one-cycle pulse: quo/rem valid for this request
- quo  output  WIDTH  quotient (LO)
- rem  output  WIDTH  remainder (HI)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, stall=0, ready=0, quo=0, rem=0, internal datapath regs=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1, annul=0, opb!=0 at edge E0: latch |opa|, |opb| (magnitudes only if signed_div, else raw), latch sign_q=opa[msb]^opb[msb], sign_r=opa[msb] (both 0 if unsigned), clear partial remainder, counter=0, go to BUSY.
  - start=1, annul=0, opb==0 at E0: go directly to DONE with quo=all ones, rem=opa. No exception raised.
- BUSY:
  - Each edge: shift {rem_acc, dividend} left 1; if shifted rem_acc >= divisor, subtract and set quotient bit 1, else 0. Use a WIDTH+1-bit compare/subtract.
  - counter increments; on the edge completing iteration WIDTH (E32 for default), apply sign fixup: quo negated if sign_q, rem negated if sign_r. Register into quo/rem, go to DONE.
- DONE: ready=1 for exactly this cycle; next edge go to IDLE unconditionally.
  - A start still high in DONE is ignored (it belongs to the completed instruction).
  - A start in the following IDLE cycle is a new request.
- Latency: ready is high in the cycle after edge E0+WIDTH (32 cycles after acceptance); divide-by-zero gives ready in the cycle after E0.
- stall = (state==IDLE & start & ~annul) | (state==BUSY). stall=0 in DONE so the pipeline advances with ready.
- annul=1 in any state: next edge go to IDLE, no ready pulse, quo/rem keep their previous values. annul has priority over start.
- quo/rem hold their last completed values until the next completion; they change only on entry to DONE.
- Signed overflow case 0x80000000 / -1: quo=0x80000000, rem=0. This falls out of magnitude arithmetic with WIDTH-bit truncation; no special path.
- Signed results follow truncation toward zero; remainder sign equals dividend sign.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, an accepted request with nonzero divisor and |opa| < |opb| (magnitudes per signedness) goes straight to DONE with quo=0, rem=opa (original, unmodified). ready is high the cycle after E0.
- Not defined: every nonzero-divisor request takes the full WIDTH iterations.

Test Plan:
- DIVU opa=100, opb=7, start held until ready -> stall high 32 cycles, ready pulse exactly once 32 cycles after acceptance, quo=14, rem=2.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). DIV opa=0x80000000, opb=0xFFFFFFFF -> quo=0x80000000, rem=0.
- DIV/DIVU opa=0x1234, opb=0 -> ready the cycle after acceptance, quo=0xFFFFFFFF, rem=0x1234, stall high only in the accept cycle.
- Start 1000/3, assert annul for one cycle at iteration 10 -> state IDLE next edge, no ready, quo/rem unchanged from prior result. Then DIVU 9/4 -> quo=2, rem=1 after 32 cycles.
- Back-to-back DIVU 50/5 then 51/5 with start re-asserted the cycle after ready -> two ready pulses, results 10/0 then 10/1. Start held during DONE does not trigger a third operation.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> ready the cycle after acceptance, quo=0, rem=3. Without the macro, the same request takes 32 cycles with identical results.
